// File: rtl/rcp_port_regs.sv
// Register-ring slave for RCP per-port statistics and the software rate value.
// Counters are snapshotted each cycle unless frozen; 64-bit reads are atomic via a LO-read-latched HI shadow.
module rcp_port_regs #(
    parameter int          NUM_PORTS         = 4,
    parameter int          UDP_REG_SRC_WIDTH = 2,
    parameter int          BLOCK_TAG         = 0,
    parameter int          REG_ADDR_WIDTH    = 6,
    parameter logic [31:0] RATE_INIT         = 32'h0
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic                         reg_req_in,
    input  logic                         reg_ack_in,
    input  logic                         reg_rd_wr_L_in,
    input  logic [22:0]                  reg_addr_in,
    input  logic [31:0]                  reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in,

    output logic                         reg_req_out,
    output logic                         reg_ack_out,
    output logic                         reg_rd_wr_L_out,
    output logic [22:0]                  reg_addr_out,
    output logic [31:0]                  reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out,

    input  logic [64*NUM_PORTS-1:0]      stat_rtt,
    input  logic [64*NUM_PORTS-1:0]      stat_bytes,
    input  logic [32*NUM_PORTS-1:0]      stat_num_rcp,

    output logic [31:0]                  rcp_rate,
    output logic                         rate_wr_pulse,
    output logic                         stats_clr_pulse
);

    localparam int TAG_W    = 23 - REG_ADDR_WIDTH;
    localparam int NUM_REGS = 4 + 5 * NUM_PORTS;

    logic        tag_hit, hit, in_range, is_wr;
    logic [31:0] off32, rd_data;

    logic                         req_q, ack_q, rdwr_q;
    logic                         req_d, ack_d, rdwr_d;
    logic [22:0]                  addr_q, addr_d;
    logic [31:0]                  data_q, data_d;
    logic [UDP_REG_SRC_WIDTH-1:0] src_q, src_d;

    logic [31:0] rate_q, rate_d;
    logic        freeze_q, freeze_d;
    logic        rate_pulse_q, rate_pulse_d;
    logic        clr_pulse_q, clr_pulse_d;

    logic [63:0] rtt_smp_q   [NUM_PORTS];
    logic [63:0] rtt_smp_d   [NUM_PORTS];
    logic [63:0] bytes_smp_q [NUM_PORTS];
    logic [63:0] bytes_smp_d [NUM_PORTS];
    logic [31:0] nrcp_smp_q  [NUM_PORTS];
    logic [31:0] nrcp_smp_d  [NUM_PORTS];
    logic [31:0] rtt_sh_q    [NUM_PORTS];
    logic [31:0] rtt_sh_d    [NUM_PORTS];
    logic [31:0] bytes_sh_q  [NUM_PORTS];
    logic [31:0] bytes_sh_d  [NUM_PORTS];

    assign tag_hit  = (reg_addr_in[22:REG_ADDR_WIDTH] == TAG_W'(BLOCK_TAG));
    assign hit      = reg_req_in && tag_hit;
    assign off32    = 32'(reg_addr_in[REG_ADDR_WIDTH-1:0]);
    assign in_range = (off32 < 32'(NUM_REGS));
    assign is_wr    = !reg_rd_wr_L_in;

    // Read mux: value of the addressed register before any write this cycle.
    always_comb begin
        rd_data = 32'hdeadbeef;
        if (off32 == 32'd0) rd_data = rate_q;
        if (off32 == 32'd1) rd_data = {31'b0, freeze_q};
        if (off32 == 32'd2) rd_data = 32'(NUM_PORTS);
        if (off32 == 32'd3) rd_data = 32'h0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (off32 == 32'(4 + 5 * p))     rd_data = rtt_smp_q[p][31:0];
            if (off32 == 32'(4 + 5 * p + 1)) rd_data = rtt_sh_q[p];
            if (off32 == 32'(4 + 5 * p + 2)) rd_data = bytes_smp_q[p][31:0];
            if (off32 == 32'(4 + 5 * p + 3)) rd_data = bytes_sh_q[p];
            if (off32 == 32'(4 + 5 * p + 4)) rd_data = nrcp_smp_q[p];
        end
    end

    always_comb begin
        rate_d       = rate_q;
        freeze_d     = freeze_q;
        rate_pulse_d = 1'b0;
        clr_pulse_d  = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rtt_smp_d[p]   = freeze_q ? rtt_smp_q[p]   : stat_rtt[64*p +: 64];
            bytes_smp_d[p] = freeze_q ? bytes_smp_q[p] : stat_bytes[64*p +: 64];
            nrcp_smp_d[p]  = freeze_q ? nrcp_smp_q[p]  : stat_num_rcp[32*p +: 32];
            rtt_sh_d[p]    = rtt_sh_q[p];
            bytes_sh_d[p]  = bytes_sh_q[p];
        end
        if (hit && in_range) begin
            if (is_wr) begin
                if (off32 == 32'd0) begin
                    rate_d       = reg_data_in;
                    rate_pulse_d = 1'b1;
                end
                if (off32 == 32'd1) begin
                    freeze_d    = reg_data_in[0];
                    clr_pulse_d = reg_data_in[1];
                end
            end else begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (off32 == 32'(4 + 5 * p))     rtt_sh_d[p]   = rtt_smp_q[p][63:32];
                    if (off32 == 32'(4 + 5 * p + 2)) bytes_sh_d[p] = bytes_smp_q[p][63:32];
                end
            end
        end
    end

    // Ring stage: hits force ack and substitute read data; everything else passes through.
    always_comb begin
        req_d  = reg_req_in;
        ack_d  = hit ? 1'b1 : reg_ack_in;
        data_d = hit ? rd_data : reg_data_in;
        rdwr_d = reg_rd_wr_L_in;
        addr_d = reg_addr_in;
        src_d  = reg_src_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q        <= 1'b0;
            ack_q        <= 1'b0;
            rdwr_q       <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            src_q        <= '0;
            rate_q       <= RATE_INIT;
            freeze_q     <= 1'b0;
            rate_pulse_q <= 1'b0;
            clr_pulse_q  <= 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                rtt_smp_q[p]   <= '0;
                bytes_smp_q[p] <= '0;
                nrcp_smp_q[p]  <= '0;
                rtt_sh_q[p]    <= '0;
                bytes_sh_q[p]  <= '0;
            end
        end else begin
            req_q        <= req_d;
            ack_q        <= ack_d;
            rdwr_q       <= rdwr_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            src_q        <= src_d;
            rate_q       <= rate_d;
            freeze_q     <= freeze_d;
            rate_pulse_q <= rate_pulse_d;
            clr_pulse_q  <= clr_pulse_d;
            for (int p = 0; p < NUM_PORTS; p++) begin
                rtt_smp_q[p]   <= rtt_smp_d[p];
                bytes_smp_q[p] <= bytes_smp_d[p];
                nrcp_smp_q[p]  <= nrcp_smp_d[p];
                rtt_sh_q[p]    <= rtt_sh_d[p];
                bytes_sh_q[p]  <= bytes_sh_d[p];
            end
        end
    end

    assign reg_req_out     = req_q;
    assign reg_ack_out     = ack_q;
    assign reg_rd_wr_L_out = rdwr_q;
    assign reg_addr_out    = addr_q;
    assign reg_data_out    = data_q;
    assign reg_src_out     = src_q;
    assign rcp_rate        = rate_q;
    assign rate_wr_pulse   = rate_pulse_q;
    assign stats_clr_pulse = clr_pulse_q;

endmodule
